// File: rtl/muldiv_pkg.sv
// Shared encodings and sizes for the iterative multiply/divide unit.
// Divide support is selected by the MULDIV_DIV_EN macro in the unit itself.
package muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_CNT_W = $clog2(MD_WIDTH);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step on a 2*WIDTH accumulator.
// Optional macro MULDIV_DIV_EN: when undefined the divide step is removed.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  input  op_e                i_op,
  output logic [2*WIDTH-1:0] o_acc_next_c
);

  // Multiply: {partial product, remaining multiplier bits}, LSB first.
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_sum      = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_sum, i_acc[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  // Divide: {partial remainder, dividend bits shifting into quotient bits}.
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic               w_fits;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_trial    = i_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_trial - {1'b0, i_opnd};
  assign w_fits     = ~w_diff[WIDTH];
  assign w_div_next = {(w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0]), i_acc[WIDTH-2:0], w_fits};

  assign o_acc_next_c = op_is_div(i_op) ? w_div_next : w_mul_next;
`else
  assign o_acc_next_c = op_is_div(i_op) ? i_acc : w_mul_next;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; fixed WIDTH+2 edge latency.
// Optional macro MULDIV_DIV_EN: enables the divide datapath (otherwise DIV/DIVU complete without writing HI/LO).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [WIDTH-1:0]   r_opnd;
  op_e                r_op;
  logic               r_neg;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
`ifdef MULDIV_DIV_EN
  logic               r_neg_rem;
  logic               r_b_zero;
  logic [WIDTH-1:0]   r_a_orig;
`endif

  op_e                w_op_in;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic               w_skip_calc;
  logic               w_load;
  logic               w_fix_we;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;
  logic [2*WIDTH-1:0] w_mul_res;

  assign w_op_in = op_e'(op);
  assign w_a_neg = op_is_signed(w_op_in) & a[WIDTH-1];
  assign w_b_neg = op_is_signed(w_op_in) & b[WIDTH-1];
  assign w_a_abs = w_a_neg ? -a : a;
  assign w_b_abs = w_b_neg ? -b : b;

`ifdef MULDIV_DIV_EN
  assign w_skip_calc = 1'b0;
`else
  assign w_skip_calc = op_is_div(w_op_in);
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_acc        (r_acc),
    .i_opnd       (r_opnd),
    .i_op         (r_op),
    .o_acc_next_c (w_acc_step)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Cancel overrides every transition, including a same-cycle start.
  always_comb begin
    w_state_nxt = r_state;
    if (cancel) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (start) w_state_nxt = w_skip_calc ? S_FIX : S_CALC;
        S_CALC:  if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = S_FIX;
        S_FIX:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Sign fix-up and result selection for the HI/LO write in FIX.
  always_comb begin
    w_load    = (r_state == S_IDLE) && start && !cancel;
    w_fix_we  = 1'b0;
    w_fix_hi  = r_hi;
    w_fix_lo  = r_lo;
    w_mul_res = r_neg ? -r_acc : r_acc;
    if (r_state == S_FIX && !cancel) begin
      if (!op_is_div(r_op)) begin
        w_fix_we = 1'b1;
        w_fix_hi = w_mul_res[2*WIDTH-1:WIDTH];
        w_fix_lo = w_mul_res[WIDTH-1:0];
      end
`ifdef MULDIV_DIV_EN
      else if (r_b_zero) begin
        w_fix_we = 1'b1;
        w_fix_hi = r_a_orig;
        w_fix_lo = {WIDTH{1'b1}};
      end else begin
        w_fix_we = 1'b1;
        w_fix_hi = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_op      <= OP_MULT;
      r_neg     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
`ifdef MULDIV_DIV_EN
      r_neg_rem <= 1'b0;
      r_b_zero  <= 1'b0;
      r_a_orig  <= '0;
`endif
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= w_fix_we || ((r_state == S_FIX) && !cancel);
      if (w_load) begin
        r_op  <= w_op_in;
        r_cnt <= '0;
        r_neg <= w_a_neg ^ w_b_neg;
        if (op_is_div(w_op_in)) begin
          r_acc  <= {{WIDTH{1'b0}}, w_a_abs};
          r_opnd <= w_b_abs;
        end else begin
          r_acc  <= {{WIDTH{1'b0}}, w_b_abs};
          r_opnd <= w_a_abs;
        end
`ifdef MULDIV_DIV_EN
        r_neg_rem <= w_a_neg;
        r_b_zero  <= (b == '0);
        r_a_orig  <= a;
`endif
      end else if (r_state == S_CALC && !cancel) begin
        r_acc <= w_acc_step;
        r_cnt <= r_cnt + 1'b1;
      end
      // The FIX result takes precedence over a same-cycle MTHI/MTLO.
      if (w_fix_we) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; divide vectors follow MULDIV_DIV_EN.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int ndone;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one start pulse, then wait (bounded) for done; lat counts edges after the start edge.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int l);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    l = 0;
    while (done !== 1'b1 && l < 100) begin
      tick();
      l++;
    end
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done === 1'b1) c++;
    end
  endtask

  task automatic mt(input logic h, input logic [31:0] d);
    hi_we = h; lo_we = !h; wdata = d;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = MULT; a = '0; b = '0;
    cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);

    // Multiply vectors
    do_op(MULT, 32'hFFFFFFFE, 32'd3, lat);
    check("mult_lat", 32'(lat), 32'd33);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);
    tick();
    check("mult_done_pulse", 32'(done), 32'd0);
    check("mult_busy_low", 32'(busy), 32'd0);

    do_op(MULTU, 32'hFFFFFFFE, 32'd3, lat);
    check("multu_hi", hi, 32'h00000002);
    check("multu_lo", lo, 32'hFFFFFFFA);
    tick();

    do_op(MULT, 32'h80000000, 32'h80000000, lat);
    check("mult_minsq_hi", hi, 32'h40000000);
    check("mult_minsq_lo", lo, 32'h00000000);
    tick();

    do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    check("multu_max_hi", hi, 32'hFFFFFFFE);
    check("multu_max_lo", lo, 32'h00000001);
    tick();

    do_op(MULT, 32'd7, 32'hFFFFFFFB, lat);
    check("mult_neg_hi", hi, 32'hFFFFFFFF);
    check("mult_neg_lo", lo, 32'hFFFFFFDD);
    tick();

    do_op(MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    check("mult_m1sq_hi", hi, 32'h00000000);
    check("mult_m1sq_lo", lo, 32'h00000001);
    tick();

`ifdef MULDIV_DIV_EN
    do_op(DIV, 32'hFFFFFFF9, 32'd2, lat);
    check("div_lat", 32'(lat), 32'd33);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    tick();

    do_op(DIVU, 32'd7, 32'd2, lat);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);
    tick();

    do_op(DIV, 32'd100, 32'hFFFFFFF9, lat);
    check("div_negdiv_lo", lo, 32'hFFFFFFF2);
    check("div_negdiv_hi", hi, 32'd2);
    tick();

    do_op(DIVU, 32'd5, 32'd0, lat);
    check("divu_zero_lo", lo, 32'hFFFFFFFF);
    check("divu_zero_hi", hi, 32'd5);
    tick();

    do_op(DIV, 32'hFFFFFFFB, 32'd0, lat);
    check("div_zero_lo", lo, 32'hFFFFFFFF);
    check("div_zero_hi", hi, 32'hFFFFFFFB);
    tick();

    do_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat);
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'h00000000);
    tick();
`else
    mt(1'b1, 32'h55);
    mt(1'b0, 32'h66);
    do_op(DIV, 32'hFFFFFFF9, 32'd2, lat);
    check("nodiv_lat", 32'(lat), 32'd1);
    check("nodiv_hi", hi, 32'h55);
    check("nodiv_lo", lo, 32'h66);
    tick();
    check("nodiv_busy_low", 32'(busy), 32'd0);
    do_op(DIVU, 32'd5, 32'd0, lat);
    check("nodivu_lat", 32'(lat), 32'd1);
    check("nodivu_hi", hi, 32'h55);
    check("nodivu_lo", lo, 32'h66);
    tick();
`endif

    // Cancel mid-CALC leaves HI/LO untouched and produces no done
    mt(1'b1, 32'h11);
    mt(1'b0, 32'h22);
    check("mthi_idle", hi, 32'h11);
    check("mtlo_idle", lo, 32'h22);
    start = 1'b1; op = MULT; a = 32'd5; b = 32'd6;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_done", 32'(done), 32'd0);
    count_done(40, ndone);
    check("cancel_no_done", 32'(ndone), 32'd0);
    check("cancel_hi", hi, 32'h11);
    check("cancel_lo", lo, 32'h22);

    start = 1'b1; cancel = 1'b1; op = MULT; a = 32'd3; b = 32'd3;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("start_cancel_busy", 32'(busy), 32'd0);
    count_done(40, ndone);
    check("start_cancel_no_done", 32'(ndone), 32'd0);
    check("start_cancel_lo", lo, 32'h22);

    // Restart during CALC is ignored; MTHI during CALC is visible then overwritten
    start = 1'b1; op = MULT; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    start = 1'b1; op = MULTU; a = 32'd100; b = 32'd100;
    tick();
    start = 1'b0;
    hi_we = 1'b1; wdata = 32'hAA;
    tick();
    hi_we = 1'b0;
    check("mthi_calc", hi, 32'hAA);
    lat = 7;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    check("restart_lat", 32'(lat), 32'd33);
    check("restart_hi", hi, 32'h0);
    check("restart_lo", lo, 32'd12);
    count_done(40, ndone);
    check("restart_single_done", 32'(ndone), 32'd0);

    // MTLO in the FIX cycle loses to the result
    start = 1'b1; op = MULT; a = 32'd2; b = 32'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 32; i++) tick();
    check("fix_busy", 32'(busy), 32'd1);
    check("fix_done_early", 32'(done), 32'd0);
    lo_we = 1'b1; wdata = 32'hDEAD;
    tick();
    lo_we = 1'b0;
    check("fix_done", 32'(done), 32'd1);
    check("fix_lo_wins", lo, 32'd6);
    tick();

    // Reset mid-CALC
    start = 1'b1; op = MULT; a = 32'd5; b = 32'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    do_op(MULTU, 32'd9, 32'd9, lat);
    check("post_rst_lat", 32'(lat), 32'd33);
    check("post_rst_lo", lo, 32'd81);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
